// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
// Holds the FSM state encoding, counter saturation helper and error-count width.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int ERR_CNT_W   = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_CNT_SAT = (1 << DEF_CNT_W) - 1;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = '1;

    // All-ones value of a w-bit counter; callers cast it to their own width.
    function automatic int sat_val(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/clk_ratio_monitor_sync_edge_det.sv
// Synchronizes an asynchronous level and flags its rising edges.
// rise lags d_in by SYNC_STAGES+1 cycles; level is delayed to line up with rise. No backpressure.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   rise_q;
    logic                   rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    // prev_q turns high on the same edge that rise_q fires, so level counts align with rise.
    assign level = prev_q;
    assign rise  = rise_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period/high time of a divided clock in fast-clock cycles and tracks ratio lock.
// Results appear one cycle after the detected rise; free-running, no backpressure.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_DIV     = 9,
    parameter int TOL         = 0,
    parameter int LOCK_CNT    = 4,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_in,
    output logic [CNT_W-1:0]     period,
    output logic [CNT_W-1:0]     high_time,
    output logic                 period_vld,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int               MC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(sat_val(CNT_W));
    localparam logic [CNT_W:0]   EXP_EXT = (CNT_W+1)'(EXP_DIV);
    localparam logic [CNT_W:0]   TOL_EXT = (CNT_W+1)'(TOL);
    localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [MC_W-1:0]  MC_FULL = MC_W'(LOCK_CNT);

    logic       sync_level;
    logic       rise;

    state_e                 state_q,      state_d;
    logic [CNT_W-1:0]       pcnt_q,       pcnt_d;
    logic [CNT_W-1:0]       hcnt_q,       hcnt_d;
    logic [MC_W-1:0]        mcnt_q,       mcnt_d;
    logic [CNT_W-1:0]       period_q,     period_d;
    logic [CNT_W-1:0]       high_time_q,  high_time_d;
    logic                   period_vld_q, period_vld_d;
    logic                   locked_q,     locked_d;
    logic                   err_q,        err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q,    err_cnt_d;

    logic [CNT_W:0]         pcnt_ext;
    logic [CNT_W:0]         pdiff;
    logic                   match;
    logic                   timeout;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk   (clk),
        .rst   (rst),
        .d_in  (div_in),
        .level (sync_level),
        .rise  (rise)
    );

    // Distance from the expected period, one bit wider so it never wraps.
    always_comb begin
        pcnt_ext = {1'b0, pcnt_q};
        pdiff    = (pcnt_ext >= EXP_EXT) ? (pcnt_ext - EXP_EXT) : (EXP_EXT - pcnt_ext);
        match    = (pdiff <= TOL_EXT);
        timeout  = (state_q != ST_IDLE) && (pcnt_q == CNT_SAT);
    end

    always_comb begin
        state_d      = state_q;
        pcnt_d       = (pcnt_q == CNT_SAT) ? pcnt_q : pcnt_q + 1'b1;
        hcnt_d       = (sync_level && (hcnt_q != CNT_SAT)) ? hcnt_q + 1'b1 : hcnt_q;
        mcnt_d       = mcnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        period_vld_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;

        // Timeout wins over a coincident rise; counters stay saturated until re-armed.
        if (timeout) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            state_d  = ST_IDLE;
        end else if (rise) begin
            pcnt_d = CNT_W'(1);
            hcnt_d = CNT_W'(1);
            unique case (state_q)
                ST_IDLE: begin
                    mcnt_d  = '0;
                    state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    period_d     = pcnt_q;
                    high_time_d  = hcnt_q;
                    period_vld_d = 1'b1;
                    if (match) begin
                        if (mcnt_q == MC_LAST) begin
                            mcnt_d   = MC_FULL;
                            locked_d = 1'b1;
                            state_d  = ST_LOCKED;
                        end else begin
                            mcnt_d = mcnt_q + 1'b1;
                        end
                    end else begin
                        err_d  = 1'b1;
                        mcnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    period_d     = pcnt_q;
                    high_time_d  = hcnt_q;
                    period_vld_d = 1'b1;
                    if (!match) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        mcnt_d   = '0;
                        state_d  = ST_MEASURE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        err_cnt_d = (err_d && (err_cnt_q != ERR_CNT_SAT)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= '0;
            hcnt_q       <= '0;
            mcnt_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            mcnt_q       <= mcnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign period_vld = period_vld_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Randomized bench for clk_ratio_monitor: two instances (TOL=0, TOL=1) share one div_in,
// and their vld/err events are compared in order against an event-level reference model.
module tb_clk_ratio_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_in;

    logic [7:0] period_o   [2];
    logic [7:0] high_o     [2];
    logic [7:0] err_cnt_o  [2];
    logic       vld_o      [2];
    logic       locked_o   [2];
    logic       err_o      [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clk_ratio_monitor u_dut0 (
        .clk(clk), .rst(rst), .div_in(div_in),
        .period(period_o[0]), .high_time(high_o[0]), .period_vld(vld_o[0]),
        .locked(locked_o[0]), .err(err_o[0]), .err_cnt(err_cnt_o[0])
    );

    clk_ratio_monitor #(.TOL(1)) u_dut1 (
        .clk(clk), .rst(rst), .div_in(div_in),
        .period(period_o[1]), .high_time(high_o[1]), .period_vld(vld_o[1]),
        .locked(locked_o[1]), .err(err_o[1]), .err_cnt(err_cnt_o[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_ev(input bit v, input int p, input int h,
                                            input bit e, input bit l, input int c);
        logic [7:0] p8, h8, c8;
        p8 = p[7:0];
        h8 = h[7:0];
        c8 = c[7:0];
        return {37'd0, v, p8, h8, e, l, c8};
    endfunction

    // ---------------- observed events ----------------
    logic [63:0] got_q  [2][$];
    logic [63:0] exp_q  [2][$];
    int          to_gap [2][$];
    int          last_vld_cyc [2];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst && (vld_o[m] || err_o[m])) begin
                got_q[m].push_back(pack_ev(vld_o[m], vld_o[m] ? int'(period_o[m]) : 0,
                                           vld_o[m] ? int'(high_o[m]) : 0,
                                           err_o[m], locked_o[m], int'(err_cnt_o[m])));
                if (vld_o[m]) last_vld_cyc[m] = cyc;
                else to_gap[m].push_back(cyc - last_vld_cyc[m]);
            end
        end
    end

    // ---------------- reference model (rise/fall times in clk cycles) ----------------
    int tolv      [2] = '{0, 1};
    bit armed     [2];
    int last_rise [2];
    int last_fall [2];
    int mc        [2];
    bit lk        [2];
    int ec        [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            armed[m] = 0; last_rise[m] = 0; last_fall[m] = 0;
            mc[m] = 0; lk[m] = 0; ec[m] = 0;
        end
    endtask

    task automatic model_rise(input int m, input int t);
        int gap, hi, dev;
        bit ok;
        if (!armed[m]) begin
            armed[m] = 1; last_rise[m] = t; mc[m] = 0;
        end else begin
            gap = t - last_rise[m];
            if (gap >= 255) begin
                // Counter saturated: one timeout error; a rise on the saturating cycle is lost.
                if (ec[m] < 255) ec[m]++;
                lk[m] = 0; mc[m] = 0;
                exp_q[m].push_back(pack_ev(0, 0, 0, 1, 0, ec[m]));
                if (gap == 255) armed[m] = 0;
                else last_rise[m] = t;
            end else begin
                hi  = last_fall[m] - last_rise[m];
                dev = (gap > 9) ? gap - 9 : 9 - gap;
                ok  = (dev <= tolv[m]);
                if (ok) begin
                    if (!lk[m]) begin
                        mc[m]++;
                        if (mc[m] >= 4) lk[m] = 1;
                    end
                end else begin
                    if (ec[m] < 255) ec[m]++;
                    lk[m] = 0; mc[m] = 0;
                end
                exp_q[m].push_back(pack_ev(1, gap, hi, !ok, lk[m], ec[m]));
                last_rise[m] = t;
            end
        end
    endtask

    // One div_in period: h cycles high then l cycles low; entered and left on a negedge.
    task automatic drive(input int h, input int l);
        div_in = 1'b1;
        for (int m = 0; m < 2; m++) model_rise(m, cyc);
        repeat (h) @(negedge clk);
        div_in = 1'b0;
        for (int m = 0; m < 2; m++) last_fall[m] = cyc;
        repeat (l) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        int n;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_nev_m%0d", tag, m), 64'(got_q[m].size()), 64'(exp_q[m].size()));
            n = (got_q[m].size() < exp_q[m].size()) ? got_q[m].size() : exp_q[m].size();
            for (int i = 0; i < n; i++)
                check($sformatf("%s_ev%0d_m%0d", tag, i, m), got_q[m][i], exp_q[m][i]);
            got_q[m].delete();
            exp_q[m].delete();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_period_m%0d", tag, m), 64'(period_o[m]), 64'd0);
            check($sformatf("%s_high_m%0d", tag, m), 64'(high_o[m]), 64'd0);
            check($sformatf("%s_flags_m%0d", tag, m), 64'({vld_o[m], locked_o[m], err_o[m]}), 64'd0);
            check($sformatf("%s_errcnt_m%0d", tag, m), 64'(err_cnt_o[m]), 64'd0);
        end
    endtask

    initial begin
        int p, h;
        rst    = 1'b1;
        div_in = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Steady divide-by-9, one cycle high.
        repeat (8) drive(1, 8);
        compare("div9");
        check("div9_locked", 64'(locked_o[0]), 64'd1);

        // Period 10: mismatch for TOL=0, lock for TOL=1.
        repeat (8) drive(1, 9);
        compare("div10");

        // Lock, one short period of 7, then relock.
        repeat (6) drive(1, 8);
        drive(2, 5);
        repeat (6) drive(1, 8);
        compare("glitch7");

        // Lock, stuck low long enough to time out, then restart.
        repeat (5) drive(1, 8);
        drive(1, 400);
        repeat (6) drive(1, 8);
        compare("stuck");
        for (int m = 0; m < 2; m++) begin
            check($sformatf("stuck_ntimeout_m%0d", m), 64'(to_gap[m].size()), 64'd1);
            if (to_gap[m].size() > 0)
                check($sformatf("stuck_delay_m%0d", m), 64'(to_gap[m][0]), 64'd255);
            to_gap[m].delete();
        end

        // Reset 5 cycles into a period while locked.
        repeat (6) drive(1, 8);
        div_in = 1'b1;
        for (int m = 0; m < 2; m++) model_rise(m, cyc);
        @(negedge clk);
        div_in = 1'b0;
        for (int m = 0; m < 2; m++) last_fall[m] = cyc;
        repeat (4) @(negedge clk);
        compare("prerst");
        check("prerst_locked", 64'(locked_o[0]), 64'd1);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        repeat (6) drive(1, 8);
        compare("postrst");

        // Random periods 7..12 biased towards 9, random duty.
        for (int i = 0; i < 80; i++) begin
            p = ($urandom_range(0, 9) < 5) ? 9 : $urandom_range(7, 12);
            h = $urandom_range(1, p - 1);
            drive(h, p - h);
        end
        compare("rand");

        // Many mismatching periods: error counter saturates.
        repeat (300) drive(3, 9);
        compare("sat");
        for (int m = 0; m < 2; m++)
            check($sformatf("sat_errcnt_m%0d", m), 64'(err_cnt_o[m]), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
